// File: rtl/out_frame_streamer.sv
// out_frame_streamer: drains the finished output frame from the 32-bit output
// memory (4 pixels per word, lane 0 in bits [7:0]) and emits it as a
// valid/ready byte stream, with a running 16-bit checksum and byte count.
//
// Ports:
//   clk_50, rst_n          clock, asynchronous active-low reset
//   start, abort           frame dump request / return to IDLE (abort wins)
//   i_out_w, i_out_h       frame size in pixels, sampled on an accepted start
//   mem_raddr, mem_rdata   word read port, 1-cycle registered read latency
//   m_data/m_valid/m_ready/m_last   byte stream
//   busy, done             not-IDLE flag, one-cycle completion pulse
//   o_cfg_err              sticky: frame larger than the memory
//   o_checksum, o_byte_count  sum (mod 2^16) and count of transferred bytes
module out_frame_streamer #(
  parameter int unsigned AW    = 10,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      i_out_w,
  input  logic [15:0]      i_out_h,
  output logic [AW-1:0]    mem_raddr,
  input  logic [31:0]      mem_rdata,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             o_cfg_err,
  output logic [15:0]      o_checksum,
  output logic [CNT_W-1:0] o_byte_count
);

  localparam int unsigned PIX_W = 32;
  localparam logic [PIX_W:0] MEM_WORDS = 33'd1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_LAT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   n_q, n_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        word_q, word_d;

  logic [AW-1:0]      mem_raddr_d;
  logic [7:0]         m_data_d;
  logic               m_valid_d, m_last_d, busy_d, done_d, cfg_err_d;
  logic [15:0]        checksum_d;
  logic [CNT_W-1:0]   byte_count_d;

  logic [PIX_W-1:0]   n_start;
  logic [PIX_W:0]     w_start;
  logic               too_big;
  logic               xfer;
  logic               last_pix;
  logic               next_last;
  logic [1:0]         lane_nx;

  // Frame geometry of the request currently on the inputs.
  always_comb begin
    n_start = PIX_W'(i_out_w) * PIX_W'(i_out_h);
    w_start = ((PIX_W+1)'(n_start) + 33'd3) >> 2;
    too_big = (w_start > MEM_WORDS);
  end

  always_comb begin
    xfer      = m_valid & m_ready;
    last_pix  = (pix_q == n_q - 32'd1);
    next_last = (pix_q + 32'd1 == n_q - 32'd1);
    lane_nx   = lane_q + 2'd1;
  end

  // Next-state and next-output logic; mem_raddr doubles as the word index.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    pix_d        = pix_q;
    lane_d       = lane_q;
    word_d       = word_q;
    mem_raddr_d  = mem_raddr;
    m_data_d     = m_data;
    m_valid_d    = m_valid;
    m_last_d     = m_last;
    done_d       = 1'b0;
    cfg_err_d    = o_cfg_err;
    checksum_d   = o_checksum;
    byte_count_d = o_byte_count;

    if (abort) begin
      state_d   = S_IDLE;
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_d          = n_start;
            pix_d        = '0;
            checksum_d   = '0;
            byte_count_d = '0;
            cfg_err_d    = 1'b0;
            if (n_start == '0) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else if (too_big) begin
              cfg_err_d = 1'b1;
              state_d   = S_FIN;
              done_d    = 1'b1;
            end else begin
              mem_raddr_d = '0;
              state_d     = S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          state_d = S_RD_LAT;
        end
        S_RD_LAT: begin
          // Present lane 0 straight from the read data so EMIT starts valid.
          word_d    = mem_rdata;
          lane_d    = 2'd0;
          m_data_d  = mem_rdata[7:0];
          m_valid_d = 1'b1;
          m_last_d  = last_pix;
          state_d   = S_EMIT;
        end
        S_EMIT: begin
          if (xfer) begin
            checksum_d   = o_checksum + 16'(m_data);
            byte_count_d = o_byte_count + CNT_W'(1);
            pix_d        = pix_q + 32'd1;
            if (last_pix) begin
              m_valid_d = 1'b0;
              m_last_d  = 1'b0;
              done_d    = 1'b1;
              state_d   = S_FIN;
            end else if (lane_q == 2'd3) begin
              m_valid_d   = 1'b0;
              m_last_d    = 1'b0;
              mem_raddr_d = mem_raddr + AW'(1);
              state_d     = S_RD_REQ;
            end else begin
              lane_d   = lane_nx;
              m_data_d = word_q[{lane_nx, 3'b000} +: 8];
              m_last_d = next_last;
            end
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d   = S_IDLE;
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      pix_q        <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      mem_raddr    <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      o_cfg_err    <= 1'b0;
      o_checksum   <= '0;
      o_byte_count <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      pix_q        <= pix_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      mem_raddr    <= mem_raddr_d;
      m_data       <= m_data_d;
      m_valid      <= m_valid_d;
      m_last       <= m_last_d;
      busy         <= busy_d;
      done         <= done_d;
      o_cfg_err    <= cfg_err_d;
      o_checksum   <= checksum_d;
      o_byte_count <= byte_count_d;
    end
  end

endmodule
